// File: rtl/edit_cursor_ctrl.sv
// Edit-flow sequencer for the clock/date/timer display: field cursor, shared
// blink phase and inc/dec request/ack handshake towards the BCD register bank.
module edit_cursor_ctrl #(
  parameter int unsigned BLINK_HALF   = 50_000_000,
  parameter int unsigned NUM_FIELDS   = 9,
  parameter int unsigned IDLE_TOGGLES = 20,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       btn_edit_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       ack_i,
  output logic [3:0] dir_o,
  output logic       cursor_o,
  output logic       blink_o,
  output logic       inc_o,
  output logic       dec_o,
  output logic       err_o
);

  localparam int unsigned BW = (BLINK_HALF   > 1) ? $clog2(BLINK_HALF)   : 1;
  localparam int unsigned IW = (IDLE_TOGGLES > 1) ? $clog2(IDLE_TOGGLES) : 1;
  localparam int unsigned AW = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TOGGLES - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    DIR_LAST   = 4'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_REQ
  } state_t;

  state_t        state;
  logic [BW-1:0] blink_cnt;
  logic [IW-1:0] idle_cnt;
  logic [AW-1:0] ack_cnt;

  logic blink_wrap_c;
  logic any_btn_c;
  logic accept_c;

  assign blink_wrap_c = (blink_cnt == BLINK_LAST);
  assign any_btn_c    = btn_edit_i | btn_left_i | btn_right_i | btn_up_i | btn_down_i;
  // Entering edit also restarts the blink so the cursor shows up immediately.
  assign accept_c     = ((state == ST_EDIT) && any_btn_c) ||
                        ((state == ST_IDLE) && btn_edit_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dir_o     <= 4'd0;
      cursor_o  <= 1'b0;
      blink_o   <= 1'b0;
      inc_o     <= 1'b0;
      dec_o     <= 1'b0;
      err_o     <= 1'b0;
      blink_cnt <= '0;
      idle_cnt  <= '0;
      ack_cnt   <= '0;
    end else begin
      err_o <= 1'b0;

      if (accept_c) begin
        blink_cnt <= '0;
        blink_o   <= 1'b1;
      end else if (blink_wrap_c) begin
        blink_cnt <= '0;
        blink_o   <= ~blink_o;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (btn_edit_i) begin
            state    <= ST_EDIT;
            cursor_o <= 1'b1;
            dir_o    <= 4'd0;
            idle_cnt <= '0;
          end
        end

        ST_EDIT: begin
          if (any_btn_c) idle_cnt <= '0;
          if (btn_edit_i) begin
            state    <= ST_IDLE;
            cursor_o <= 1'b0;
          end else if (btn_up_i) begin
            state   <= ST_REQ;
            inc_o   <= 1'b1;
            ack_cnt <= '0;
          end else if (btn_down_i) begin
            state   <= ST_REQ;
            dec_o   <= 1'b1;
            ack_cnt <= '0;
          end else if (btn_right_i) begin
            dir_o <= (dir_o == DIR_LAST) ? 4'd0 : dir_o + 4'd1;
          end else if (btn_left_i) begin
            dir_o <= (dir_o == 4'd0) ? DIR_LAST : dir_o - 4'd1;
          end else if (blink_wrap_c) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= ST_IDLE;
              cursor_o <= 1'b0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end

        ST_REQ: begin
          // An ack on the final wait cycle still wins over the abort.
          if (ack_i) begin
            state <= ST_EDIT;
            inc_o <= 1'b0;
            dec_o <= 1'b0;
          end else if (ack_cnt == ACK_LAST) begin
            state <= ST_EDIT;
            inc_o <= 1'b0;
            dec_o <= 1'b0;
            err_o <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// Scoreboard bench for edit_cursor_ctrl: a behavioural model predicts every
// cycle's outputs into a queue, a monitor pops and compares after each edge.
module tb_edit_cursor_ctrl;

  localparam int BH = 4;
  localparam int NF = 9;
  localparam int IT = 3;
  localparam int AT = 5;

  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_REQ  = 2;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_edit_i = 1'b0;
  logic       btn_left_i = 1'b0;
  logic       btn_right_i = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic       ack_i = 1'b0;
  logic [3:0] dir_o;
  logic       cursor_o;
  logic       blink_o;
  logic       inc_o;
  logic       dec_o;
  logic       err_o;

  edit_cursor_ctrl #(
    .BLINK_HALF  (BH),
    .NUM_FIELDS  (NF),
    .IDLE_TOGGLES(IT),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .btn_edit_i (btn_edit_i),
    .btn_left_i (btn_left_i),
    .btn_right_i(btn_right_i),
    .btn_up_i   (btn_up_i),
    .btn_down_i (btn_down_i),
    .ack_i      (ack_i),
    .dir_o      (dir_o),
    .cursor_o   (cursor_o),
    .blink_o    (blink_o),
    .inc_o      (inc_o),
    .dec_o      (dec_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int         cyc;
    logic [3:0] dir;
    logic       cursor;
    logic       blink;
    logic       inc;
    logic       dec;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int m_edge   = 0;
  int m_mode   = M_IDLE;
  int m_dir    = 0;
  int m_idle   = 0;
  int m_age    = 0;
  int m_delay  = 0;
  int m_anchor = 0;
  bit m_aval   = 1'b0;
  bit m_inc    = 1'b0;
  bit m_dec    = 1'b0;
  bit m_err    = 1'b0;

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s edge %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  // Drive one cycle of inputs and predict outputs after the next rising edge.
  task automatic step(input bit rst, input bit e, input bit l, input bit r,
                      input bit u, input bit d, input bit a);
    exp_t x;
    bit   tog;
    bit   acc;
    @(negedge clk_i);
    rst_n       = rst;
    btn_edit_i  = e;
    btn_left_i  = l;
    btn_right_i = r;
    btn_up_i    = u;
    btn_down_i  = d;
    ack_i       = a;
    m_edge++;
    if (!rst) begin
      m_mode = M_IDLE; m_dir = 0; m_idle = 0; m_age = 0;
      m_inc = 1'b0; m_dec = 1'b0; m_err = 1'b0;
      m_anchor = m_edge; m_aval = 1'b0;
    end else begin
      tog   = ((m_edge - m_anchor) % BH) == 0;
      acc   = 1'b0;
      m_err = 1'b0;
      if (m_mode == M_IDLE) begin
        if (e) begin
          m_mode = M_EDIT; m_dir = 0; m_idle = 0; acc = 1'b1;
        end
      end else if (m_mode == M_EDIT) begin
        if (e | l | r | u | d) begin
          acc = 1'b1; m_idle = 0;
        end
        if (e) m_mode = M_IDLE;
        else if (u) begin
          m_mode = M_REQ; m_inc = 1'b1; m_age = 0; m_delay = $urandom_range(7, 0);
        end else if (d) begin
          m_mode = M_REQ; m_dec = 1'b1; m_age = 0; m_delay = $urandom_range(7, 0);
        end else if (r) m_dir = (m_dir + 1) % NF;
        else if (l) m_dir = (m_dir + NF - 1) % NF;
        else if (tog) begin
          m_idle++;
          if (m_idle == IT) begin
            m_mode = M_IDLE; m_idle = 0;
          end
        end
      end else begin
        if (a) begin
          m_mode = M_EDIT; m_inc = 1'b0; m_dec = 1'b0;
        end else begin
          m_age++;
          if (m_age == AT) begin
            m_mode = M_EDIT; m_inc = 1'b0; m_dec = 1'b0; m_err = 1'b1;
          end
        end
      end
      if (acc) begin
        m_anchor = m_edge; m_aval = 1'b1;
      end
    end
    x.cyc    = m_edge;
    x.dir    = 4'(m_dir);
    x.cursor = (m_mode != M_IDLE);
    x.blink  = m_aval ^ (((m_edge - m_anchor) / BH) % 2 == 1);
    x.inc    = m_inc;
    x.dec    = m_dec;
    x.err    = m_err;
    exp_q.push_back(x);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit e, input bit l, input bit r, input bit u, input bit d);
    step(1'b1, e, l, r, u, d, 1'b0);
  endtask

  function automatic bit hit(input int unsigned pct);
    return ($urandom % 100) < pct;
  endfunction

  // Monitor: compare whatever the model predicted for this edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("dir",    x.cyc, 32'(dir_o),    32'(x.dir));
        chk("cursor", x.cyc, 32'(cursor_o), 32'(x.cursor));
        chk("blink",  x.cyc, 32'(blink_o),  32'(x.blink));
        chk("inc",    x.cyc, 32'(inc_o),    32'(x.inc));
        chk("dec",    x.cyc, 32'(dec_o),    32'(x.dec));
        chk("err",    x.cyc, 32'(err_o),    32'(x.err));
      end
    end
  end

  initial begin
    bit          busy;
    int unsigned p;
    bit          a;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(12);

    // Navigation with wrap in both directions
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Handshake acked on the third request cycle
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet(2);

    // Abort on missing ack, buttons ignored while waiting
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    quiet(6);

    // Ack on the timeout cycle wins
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    quiet(4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Priority: edit beats up and right
    press(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    quiet(3);

    // Idle timeout, then reset during a pending request
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(14);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    quiet(3);

    // Randomised phases alternating busy and quiet button activity
    for (int i = 0; i < 3000; i++) begin
      busy = ((i / 150) % 2) == 0;
      p    = busy ? 12 : 1;
      if (m_mode == M_REQ) a = (m_age == m_delay);
      else a = hit(10);
      step(!hit(busy ? 1 : 0), hit(busy ? 3 : 1), hit(p), hit(p), hit(p), hit(p), a);
    end

    @(posedge clk_i);
    #2;
    chk("drain", m_edge, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
